// File: rtl/alu_muldiv.sv
// alu_muldiv: registered execute-stage ALU with an iterative multiply/divide unit and HI/LO registers
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       aluControl,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic [WIDTH-1:0] aluOut,
  output logic             zeroFlag,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] alu_q, alu_d, hi_q, hi_d, lo_q, lo_d, b_q, b_d, res;
  logic [2*WIDTH-1:0] acc_q, acc_d, mul_next, div_next, prod;
  logic [CW-1:0] cnt_q, cnt_d;
  logic div_q, div_d, neg_q, neg_d, sa_q, sa_d, done_q, done_d;
  logic accept, multi, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b, quo, rem;
  logic [WIDTH:0] mul_sum, rem_sh, rem_diff;
  assign accept = state_q == IDLE && start;
  assign multi  = aluControl[3:2] == 2'b10;
  assign sa     = !aluControl[0] && srcA[WIDTH-1];
  assign sb     = !aluControl[0] && srcB[WIDTH-1];
  assign mag_a  = sa ? -srcA : srcA;
  assign mag_b  = sb ? -srcB : srcB;
  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign rem_diff = rem_sh - {1'b0, b_q};
  assign div_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign prod = neg_q ? -acc_q : acc_q;
  assign quo  = b_q == '0 ? '1 : neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  always_comb begin
    case (aluControl)
      4'b0000: res = srcA & srcB;
      4'b0001: res = srcA | srcB;
      4'b0010: res = srcA + srcB;
      4'b0011: res = srcA ^ srcB;
      4'b0100: res = ~(srcA | srcB);
      4'b0101: res = WIDTH'(srcA < srcB);
      4'b0110: res = srcA - srcB;
      4'b0111: res = WIDTH'($signed(srcA) < $signed(srcB));
      4'b1100: res = hi_q;
      4'b1101: res = lo_q;
      default: res = srcA;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end
  always_comb begin
    case (state_q)
      IDLE:    state_d = accept && multi ? RUN : IDLE;
      RUN:     state_d = cnt_q == CW'(WIDTH - 1) ? FIX : RUN;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy     = state_q != IDLE;
    done     = done_q;
    aluOut   = alu_q;
    zeroFlag = alu_q == '0;
    hi       = hi_q;
    lo       = lo_q;
  end
  always_comb begin
    alu_d  = alu_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    acc_d  = acc_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    neg_d  = neg_q;
    sa_d   = sa_q;
    done_d = 1'b0;
    if (accept && multi) begin
      acc_d = {{WIDTH{1'b0}}, mag_a};
      b_d   = mag_b;
      cnt_d = '0;
      div_d = aluControl[1];
      neg_d = sa ^ sb;
      sa_d  = sa;
    end else if (accept) begin
      alu_d  = res;
      done_d = 1'b1;
      hi_d   = aluControl == 4'b1110 ? srcA : hi_q;
      lo_d   = aluControl == 4'b1111 ? srcA : lo_q;
    end else if (state_q == RUN) begin
      acc_d = div_q ? div_next : mul_next;
      cnt_d = cnt_q + 1'b1;
    end else if (state_q == FIX) begin
      {hi_d, lo_d} = div_q ? {rem, quo} : prod;
      done_d       = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      acc_q  <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      sa_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      alu_q  <= alu_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      acc_q  <= acc_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      neg_q  <= neg_d;
      sa_q   <= sa_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vector table plus handshake, back-to-back and reset-abort sequences
module tb_alu_muldiv;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0] aluControl = '0;
  logic [31:0] srcA = '0, srcB = '0;
  logic [31:0] aluOut, hi, lo;
  logic zeroFlag, busy, done;
  int checks = 0, failures = 0;
  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .aluControl(aluControl),
    .srcA(srcA), .srcB(srcB), .aluOut(aluOut), .zeroFlag(zeroFlag),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, alu, hi, lo;
    int          lat;
  } vec_t;
  vec_t v[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     output int lat, output logic busy1, output logic [63:0] hilo1);
    @(negedge clk);
    aluControl = op;
    srcA = a;
    srcB = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy1 = busy;
    hilo1 = {hi, lo};
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask
  initial begin
    int lat, nd, dc;
    logic b1;
    logic [63:0] hl1, prev_hl;
    v.push_back('{4'h2, 32'd7, 32'd5, 32'd12, 32'h0, 32'h0, 1});
    v.push_back('{4'h6, 32'd5, 32'd5, 32'd0, 32'h0, 32'h0, 1});
    v.push_back('{4'h2, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h0, 32'h0, 1});
    v.push_back('{4'h7, 32'hFFFFFFFF, 32'd1, 32'd1, 32'h0, 32'h0, 1});
    v.push_back('{4'h5, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h0, 32'h0, 1});
    v.push_back('{4'h0, 32'hF0F0FF00, 32'h0FF00F0F, 32'h00F00F00, 32'h0, 32'h0, 1});
    v.push_back('{4'h1, 32'hF0F0FF00, 32'h0FF00F0F, 32'hFFF0FF0F, 32'h0, 32'h0, 1});
    v.push_back('{4'h3, 32'hF0F0FF00, 32'h0FF00F0F, 32'hFF00F00F, 32'h0, 32'h0, 1});
    v.push_back('{4'h4, 32'h0F0F0000, 32'hF00000FF, 32'h00F0FF00, 32'h0, 32'h0, 1});
    v.push_back('{4'h2, 32'd12, 32'd3, 32'd15, 32'h0, 32'h0, 1});
    v.push_back('{4'h8, 32'hFFFFFFFD, 32'd5, 32'd15, 32'hFFFFFFFF, 32'hFFFFFFF1, 34});
    v.push_back('{4'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd15, 32'hFFFFFFFE, 32'h1, 34});
    v.push_back('{4'hB, 32'd100, 32'd7, 32'd15, 32'd2, 32'd14, 34});
    v.push_back('{4'hA, 32'hFFFFFFF9, 32'd2, 32'd15, 32'hFFFFFFFF, 32'hFFFFFFFD, 34});
    v.push_back('{4'hA, 32'h80000000, 32'hFFFFFFFF, 32'd15, 32'h0, 32'h80000000, 34});
    v.push_back('{4'hB, 32'd9, 32'd0, 32'd15, 32'd9, 32'hFFFFFFFF, 34});
    v.push_back('{4'hA, 32'hFFFFFFF9, 32'd0, 32'd15, 32'hFFFFFFF9, 32'hFFFFFFFF, 34});
    v.push_back('{4'h8, 32'd7, 32'hFFFFFFFD, 32'd15, 32'hFFFFFFFF, 32'hFFFFFFEB, 34});
    v.push_back('{4'hA, 32'd7, 32'hFFFFFFFE, 32'd15, 32'd1, 32'hFFFFFFFD, 34});
    v.push_back('{4'hE, 32'h1234, 32'd0, 32'h1234, 32'h1234, 32'hFFFFFFFD, 1});
    v.push_back('{4'hC, 32'd0, 32'd0, 32'h1234, 32'h1234, 32'hFFFFFFFD, 1});
    v.push_back('{4'hF, 32'h55, 32'd0, 32'h55, 32'h1234, 32'h55, 1});
    v.push_back('{4'hD, 32'd0, 32'd0, 32'h55, 32'h1234, 32'h55, 1});
    v.push_back('{4'h7, 32'd1, 32'hFFFFFFFF, 32'd0, 32'h1234, 32'h55, 1});
    v.push_back('{4'h7, 32'h80000000, 32'h7FFFFFFF, 32'd1, 32'h1234, 32'h55, 1});
    v.push_back('{4'h6, 32'd3, 32'd5, 32'hFFFFFFFE, 32'h1234, 32'h55, 1});
    v.push_back('{4'h9, 32'h10000, 32'h10000, 32'hFFFFFFFE, 32'd1, 32'h0, 34});
    v.push_back('{4'hB, 32'hFFFFFFFF, 32'd16, 32'hFFFFFFFE, 32'hF, 32'h0FFFFFFF, 34});
    #12;
    chk("rst_alu", aluOut, 0);
    chk("rst_zero", zeroFlag, 1);
    chk("rst_hilo", {hi, lo}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    @(negedge clk) reset = 1'b0;
    prev_hl = 0;
    foreach (v[i]) begin
      run(v[i].op, v[i].a, v[i].b, lat, b1, hl1);
      chk($sformatf("v%0d_lat", i), lat, v[i].lat);
      chk($sformatf("v%0d_alu", i), aluOut, v[i].alu);
      chk($sformatf("v%0d_zero", i), zeroFlag, v[i].alu == 0);
      chk($sformatf("v%0d_hi", i), hi, v[i].hi);
      chk($sformatf("v%0d_lo", i), lo, v[i].lo);
      chk($sformatf("v%0d_busy_done", i), busy, 0);
      if (v[i].lat > 1) begin
        chk($sformatf("v%0d_busy_run", i), b1, 1);
        chk($sformatf("v%0d_hilo_hold", i), hl1, prev_hl);
      end
      prev_hl = {v[i].hi, v[i].lo};
    end
    // start during a multiply is ignored
    @(negedge clk);
    aluControl = 4'h8; srcA = 32'd3; srcB = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    nd = 0; dc = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      start = c == 5;
      aluControl = 4'h2; srcA = 32'd1; srcB = 32'd1;
      @(posedge clk);
      #1 start = 1'b0;
      if (done) begin nd++; dc = c; end
    end
    chk("ign_ndone", nd, 1);
    chk("ign_donecyc", dc, 33);
    chk("ign_alu", aluOut, 32'hFFFFFFFE);
    chk("ign_hilo", {hi, lo}, 64'h0000_0000_0000_000F);
    // back-to-back singles, then done must drop
    run(4'h2, 32'd1, 32'd2, lat, b1, hl1);
    chk("b2b_1", {done, aluOut}, {1'b1, 32'd3});
    run(4'h6, 32'd10, 32'd3, lat, b1, hl1);
    chk("b2b_2", {done, aluOut}, {1'b1, 32'd7});
    @(posedge clk);
    #1 chk("b2b_drop", done, 0);
    // accept in the done cycle of a divide
    run(4'hB, 32'd100, 32'd7, lat, b1, hl1);
    chk("dc_div", {hi, lo}, {32'd2, 32'd14});
    run(4'h2, 32'd2, 32'd2, lat, b1, hl1);
    chk("dc_add", {lat, aluOut}, {32'd1, 32'd4});
    // reset mid-divide
    @(negedge clk);
    aluControl = 4'hA; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hilo", {hi, lo}, 0);
    chk("abort_alu_zero", {aluOut, zeroFlag}, {32'd0, 1'b1});
    @(negedge clk) reset = 1'b0;
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1 if (done) nd++;
    end
    chk("abort_nodone", nd, 0);
    run(4'hB, 32'd100, 32'd7, lat, b1, hl1);
    chk("post_lat", lat, 34);
    chk("post_div", {hi, lo}, {32'd2, 32'd14});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
